adder_arbiter: RTL

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arb_pkg.sv | 6 +
 rtl/adder_cla.sv | 30 +++
 rtl/adder_rr_grant.sv | 20 ++
 rtl/adder_arbiter.sv | 72 +++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared FSM state type and default sizing for the adder arbiter
package adder_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam int WIDTH_DEF = 32;
  localparam int N_REQ_DEF = 4;
endpackage

// File: rtl/adder_cla.sv
// adder_cla: WIDTH-bit parallel-prefix carry-lookahead adder with carry-in/out
module adder_cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_co
);
  function automatic logic [WIDTH:0] cla(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    logic [WIDTH-1:0] g, p, h, ng, np;
    h = a ^ b;
    p = h;
    g = a & b;
    g[0] = g[0] | (h[0] & ci);
    for (int d = 1; d < WIDTH; d = d * 2) begin
      ng = g;
      np = p;
      for (int i = d; i < WIDTH; i++) begin
        ng[i] = g[i] | (p[i] & g[i-d]);
        np[i] = p[i] & p[i-d];
      end
      g = ng;
      p = np;
    end
    return {g[WIDTH-1], h ^ {g[WIDTH-2:0], ci}};
  endfunction
  assign {o_co, o_sum} = cla(i_a, i_b, i_ci);
endmodule

// File: rtl/adder_rr_grant.sv
// adder_rr_grant: combinational round-robin pick of the first request at or above the pointer
module adder_rr_grant #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_idx
);
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_grant = N'(1) << ((int'(i_ptr) + k) % N);
        o_idx   = IDW'((int'(i_ptr) + k) % N);
      end
  end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one carry-lookahead adder among N_REQ requesters
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_ci,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [WIDTH-1:0]       resp_sum,
  output logic                   resp_co
);
  state_t           r_state;
  logic [IDW-1:0]   r_ptr, r_id, w_idx;
  logic [WIDTH-1:0] r_a, r_b, w_sum;
  logic             r_ci, w_co, w_acc;
  logic [N_REQ-1:0] w_grant;
  adder_rr_grant #(.N(N_REQ), .IDW(IDW)) u_grant (
    .i_req(req_valid), .i_ptr(r_ptr), .o_grant(w_grant), .o_idx(w_idx)
  );
  adder_cla #(.WIDTH(WIDTH)) u_cla (
    .i_a(r_a), .i_b(r_b), .i_ci(r_ci), .o_sum(w_sum), .o_co(w_co)
  );
  // grant is suppressed while reset is held so nothing looks accepted mid-reset
  assign req_ready = (r_state == IDLE && !rst) ? w_grant : '0;
  assign w_acc     = |(req_valid & req_ready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_ci       <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_co    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_a     <= req_a[int'(w_idx)*WIDTH +: WIDTH];
          r_b     <= req_b[int'(w_idx)*WIDTH +: WIDTH];
          r_ci    <= req_ci[w_idx];
          r_id    <= w_idx;
          r_ptr   <= IDW'((int'(w_idx) + 1) % N_REQ);
          r_state <= EXEC;
        end
        EXEC: begin
          {resp_co, resp_sum} <= {w_co, w_sum};
          resp_id    <= r_id;
          resp_valid <= 1'b1;
          r_state    <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
